// File: rtl/oldland_dmem_responder.sv
// Word-addressed data-memory target for the oldland bus: decodes a window of
// MEM_WORDS words at BASE_WORD, with byte-lane writes and a fixed wait count.
//
// state     | meaning
// S_IDLE    | waiting for d_access; request fields captured on the sampling edge
// S_WAIT    | in-range request counting down r_cnt before completing
// S_RESPOND | one-cycle ack or error pulse, then back to S_IDLE
module oldland_dmem_responder #(
  parameter logic [29:0] BASE_WORD   = 30'h0000_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  input  logic        d_access,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error
);

  localparam int         AW       = $clog2(MEM_WORDS);
  localparam bit         NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic [AW-1:0]  r_idx;
  logic [3:0]     r_be;
  logic           r_we;
  logic [31:0]    r_wval;
  logic [31:0]    r_data;
  logic           r_ack;
  logic           r_error;
  logic [31:0]    r_mem [MEM_WORDS];

  logic [29:0]    w_diff;
  logic           w_in_range;
  logic           w_fire_now;
  logic           w_fire_wait;
  logic [AW-1:0]  w_acc_idx;
  logic [3:0]     w_acc_be;
  logic           w_acc_we;
  logic [31:0]    w_acc_wval;
  logic [31:0]    w_rd_word;
  logic [31:0]    w_wr_word;
  logic           w_mem_we;

  assign w_diff      = d_addr - BASE_WORD;
  assign w_in_range  = (w_diff < 30'(MEM_WORDS));
  assign w_fire_now  = (r_state == S_IDLE) && d_access && w_in_range && NO_WAIT;
  assign w_fire_wait = (r_state == S_WAIT) && (r_cnt == 4'd0);

  // Zero-wait requests complete on the sampling edge, so they use the live inputs.
  assign w_acc_idx   = w_fire_now ? w_diff[AW-1:0] : r_idx;
  assign w_acc_be    = w_fire_now ? d_bytesel      : r_be;
  assign w_acc_we    = w_fire_now ? d_wr_en        : r_we;
  assign w_acc_wval  = w_fire_now ? d_wr_val       : r_wval;
  assign w_rd_word   = r_mem[w_acc_idx];
  assign w_mem_we    = (w_fire_now || w_fire_wait) && w_acc_we;

  always_comb begin
    w_wr_word = w_rd_word;
    for (int i = 0; i < 4; i++) begin
      if (w_acc_be[i]) w_wr_word[8*i +: 8] = w_acc_wval[8*i +: 8];
    end
  end

  // Storage has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_acc_idx] <= w_wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_be    <= 4'd0;
      r_we    <= 1'b0;
      r_wval  <= 32'd0;
      r_data  <= 32'd0;
      r_ack   <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_data  <= 32'd0;
      r_ack   <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (d_access) begin
            r_idx  <= w_diff[AW-1:0];
            r_be   <= d_bytesel;
            r_we   <= d_wr_en;
            r_wval <= d_wr_val;
            if (!w_in_range) begin
              r_error <= 1'b1;
              r_state <= S_RESPOND;
            end else if (NO_WAIT) begin
              r_ack   <= 1'b1;
              r_data  <= d_wr_en ? 32'd0 : w_rd_word;
              r_state <= S_RESPOND;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_ack   <= 1'b1;
            r_data  <= r_we ? 32'd0 : w_rd_word;
            r_state <= S_RESPOND;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESPOND: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign d_data  = r_data;
  assign d_ack   = r_ack;
  assign d_error = r_error;

endmodule

// File: tb/tb_oldland_dmem_responder.sv
// Bench for oldland_dmem_responder: five instances with different base/wait
// settings driven from a vector table plus hand-written multi-cycle sequences.
module tb_oldland_dmem_responder;

  localparam int NI = 5;

  function automatic int ws_of(input int k);
    case (k)
      2:       return 0;
      3:       return 3;
      4:       return 2;
      default: return 1;
    endcase
  endfunction

  logic                  clk = 1'b0;
  logic [NI-1:0]         rst_n;
  logic [NI-1:0]         d_wr_en, d_access, d_ack, d_error;
  logic [NI-1:0][29:0]   d_addr;
  logic [NI-1:0][3:0]    d_bytesel;
  logic [NI-1:0][31:0]   d_wr_val, d_data;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    oldland_dmem_responder #(
      .BASE_WORD  ((g == 1) ? 30'h100 : 30'h0),
      .MEM_WORDS  (1024),
      .WAIT_STATES((g == 2) ? 0 : ((g == 3) ? 3 : ((g == 4) ? 2 : 1)))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .d_addr   (d_addr[g]),
      .d_bytesel(d_bytesel[g]),
      .d_wr_en  (d_wr_en[g]),
      .d_wr_val (d_wr_val[g]),
      .d_access (d_access[g]),
      .d_data   (d_data[g]),
      .d_ack    (d_ack[g]),
      .d_error  (d_error[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          err;
    int          lat;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int          k;
    logic [29:0] a;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wv;
    bit          err;
    logic [31:0] rd;
    bit          chk;
  } vec_t;

  vec_t tbl[$];

  // Called with the DUT idle; the next rising edge samples the request.
  task automatic run_req(input int k, input logic [29:0] a, input logic [3:0] be,
                         input logic we, input logic [31:0] wv, input bit exp_err,
                         input logic [31:0] exp_data, input bit chk, input int drop_at);
    exp_t e;
    int   lat;
    bit   seen;
    bit   bad_idle;
    e.err      = exp_err;
    e.lat      = exp_err ? 1 : ws_of(k) + 1;
    e.data     = exp_data;
    e.chk_data = chk;
    sb.push_back(e);
    d_addr[k]    = a;
    d_bytesel[k] = be;
    d_wr_en[k]   = we;
    d_wr_val[k]  = wv;
    d_access[k]  = 1'b1;
    seen = 1'b0;
    lat = 0;
    bad_idle = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (d_ack[k] || d_error[k]) begin
        seen = 1'b1;
        lat  = c;
      end else if (d_data[k] !== 32'd0) begin
        bad_idle = 1'b1;
      end
      if (c == drop_at) begin
        d_access[k]  = 1'b0;
        d_addr[k]    = 30'($urandom);
        d_wr_val[k]  = $urandom;
        d_wr_en[k]   = ~we;
        d_bytesel[k] = 4'hF;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: inst %0d addr 0x%h got no response, expected one", k, a);
    end else begin
      check("latency", 32'(lat), 32'(e.lat));
      check("error_flag", 32'(d_error[k]), 32'(e.err));
      check("ack_flag", 32'(d_ack[k]), 32'(!e.err));
      if (e.chk_data) check("rdata", d_data[k], e.data);
    end
    check("data_zero_without_ack", 32'(bad_idle), 32'd0);
    @(posedge clk);
    #1;
    d_access[k] = 1'b0;
    @(negedge clk);
    check("single_cycle_pulse", 32'({d_ack[k], d_error[k]}), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ack_pat;
    logic [3:0] err_pat;
    bit         seen;

    rst_n     = '0;
    d_wr_en   = '0;
    d_access  = '0;
    d_addr    = '0;
    d_bytesel = '0;
    d_wr_val  = '0;

    // k, addr, be, we, wdata, expect error, expected read data, check data
    tbl.push_back('{0, 30'h005,      4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{0, 30'h005,      4'hF, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1});
    tbl.push_back('{0, 30'h009,      4'hF, 1'b1, 32'h11223344, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{0, 30'h009,      4'h5, 1'b1, 32'hAABBCCDD, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{0, 30'h009,      4'h0, 1'b0, 32'h0,        1'b0, 32'h11BB33DD, 1'b1});
    tbl.push_back('{0, 30'h009,      4'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{0, 30'h009,      4'h3, 1'b0, 32'h0,        1'b0, 32'h11BB33DD, 1'b1});
    tbl.push_back('{0, 30'h3FF,      4'hF, 1'b1, 32'h00000000, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{0, 30'h3FF,      4'hA, 1'b1, 32'h12345678, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{0, 30'h3FF,      4'hF, 1'b0, 32'h0,        1'b0, 32'h12005600, 1'b1});
    tbl.push_back('{0, 30'h000,      4'hF, 1'b1, 32'h01020304, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{0, 30'h400,      4'hF, 1'b1, 32'h99999999, 1'b1, 32'h0,        1'b1});
    tbl.push_back('{0, 30'h3FFFFFFF, 4'hF, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{0, 30'h000,      4'hF, 1'b0, 32'h0,        1'b0, 32'h01020304, 1'b1});
    tbl.push_back('{1, 30'h100,      4'hF, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1, 30'h4FF,      4'hF, 1'b1, 32'h0BADC0DE, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1, 30'h500,      4'hF, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{1, 30'h0FF,      4'hF, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{1, 30'h500,      4'hF, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1});
    tbl.push_back('{1, 30'h0FF,      4'hF, 1'b1, 32'h55555555, 1'b1, 32'h0,        1'b1});
    tbl.push_back('{1, 30'h100,      4'hF, 1'b0, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1});
    tbl.push_back('{1, 30'h4FF,      4'hF, 1'b0, 32'h0,        1'b0, 32'h0BADC0DE, 1'b1});
    tbl.push_back('{2, 30'h000,      4'hF, 1'b1, 32'h0000AAAA, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{2, 30'h001,      4'hF, 1'b1, 32'h0000BBBB, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{2, 30'h001,      4'hF, 1'b0, 32'h0,        1'b0, 32'h0000BBBB, 1'b1});
    tbl.push_back('{3, 30'h007,      4'hF, 1'b1, 32'h11111111, 1'b0, 32'h0,        1'b0});

    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset_data", d_data[k], 32'd0);
      check("reset_flags", 32'({d_ack[k], d_error[k]}), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = '1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      run_req(tbl[i].k, tbl[i].a, tbl[i].be, tbl[i].we, tbl[i].wv,
              tbl[i].err, tbl[i].rd, tbl[i].chk, 0);
    end

    // Zero-wait back-to-back reads with d_access held: acks in cycles 1 and 3.
    d_addr[2]    = 30'h000;
    d_bytesel[2] = 4'hF;
    d_wr_en[2]   = 1'b0;
    d_access[2]  = 1'b1;
    ack_pat = '0;
    err_pat = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      ack_pat[c-1] = d_ack[2];
      err_pat[c-1] = d_error[2];
      if (c == 1) check("b2b_first_rdata", d_data[2], 32'h0000AAAA);
      if (c == 2) d_addr[2] = 30'h001;
      if (c == 3) begin
        check("b2b_second_rdata", d_data[2], 32'h0000BBBB);
        d_access[2] = 1'b0;
      end
    end
    check("b2b_ack_pattern", 32'(ack_pat), 32'h5);
    check("b2b_err_pattern", 32'(err_pat), 32'h0);

    // Reset pulse in the middle of a WAIT_STATES=3 write abandons it.
    d_addr[3]    = 30'h007;
    d_bytesel[3] = 4'hF;
    d_wr_en[3]   = 1'b1;
    d_wr_val[3]  = 32'h22222222;
    d_access[3]  = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (d_ack[3] || d_error[3]) seen = 1'b1;
    end
    rst_n[3]    = 1'b0;
    d_access[3] = 1'b0;
    #1;
    check("midwait_reset_flags", 32'({d_ack[3], d_error[3]}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n[3] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (d_ack[3] || d_error[3]) seen = 1'b1;
    end
    check("midwait_reset_no_ack", 32'(seen), 32'd0);
    run_req(3, 30'h007, 4'hF, 1'b0, 32'h0, 1'b0, 32'h11111111, 1'b1, 0);

    // d_access dropped (and request inputs scrambled) one cycle into WAIT.
    run_req(4, 30'h003, 4'hF, 1'b1, 32'h77777777, 1'b0, 32'h0, 1'b0, 1);
    run_req(4, 30'h003, 4'hF, 1'b0, 32'h0, 1'b0, 32'h77777777, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
